// File: rtl/main_memory_responder.sv
// Backing main-memory model answering cache block fills and writebacks as
// fixed-latency, one-word-per-cycle bursts on the cache's lower-side interface.
module main_memory_responder #(
    parameter int data_length    = 32,
    parameter int address_length = 10,
    parameter int block_words    = 4,
    parameter int latency        = 4
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic                                            mem_req,
    input  logic                                            mem_write,
    input  logic [address_length-$clog2(block_words)-1:0]   mem_block_addr,
    input  logic [data_length-1:0]                          mem_wdata,
    output logic                                            mem_ready,
    output logic [data_length-1:0]                          mem_rdata,
    output logic                                            mem_rdata_valid,
    output logic                                            mem_wdata_ack,
    output logic [$clog2(block_words)-1:0]                  mem_beat,
    output logic                                            mem_done
);

    localparam int BEAT_W = $clog2(block_words);
    localparam int BLK_W  = address_length - BEAT_W;
    localparam int DEPTH  = 2 ** address_length;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(block_words - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [7:0]        LAT_INIT  = 8'((latency > 0) ? latency - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        XFER,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [BLK_W-1:0]    block_q, block_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                ready_q, ready_d;
    logic                rvalid_q, rvalid_d;
    logic                wack_q, wack_d;
    logic                done_q, done_d;

    logic [data_length-1:0]    mem_q [DEPTH];
    logic [address_length-1:0] word_addr;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        block_d = block_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;

        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    write_d = mem_write;
                    block_d = mem_block_addr;
                    beat_d  = '0;
                    if (latency == 0) begin
                        state_d = XFER;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = XFER;
                    beat_d  = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            XFER: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BEAT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        ready_d  = (state_d == IDLE);
        rvalid_d = (state_d == XFER) && !write_d;
        wack_d   = (state_d == XFER) && write_d;
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            block_q  <= '0;
            cnt_q    <= '0;
            beat_q   <= '0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            wack_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            block_q  <= block_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            wack_q   <= wack_d;
            done_q   <= done_d;
        end
    end

    assign word_addr = {block_q, beat_q};

    // Storage is deliberately not reset; reset only blocks the in-flight write beat.
    always_ff @(posedge clock) begin
        if (!reset && wack_q) begin
            mem_q[word_addr] <= mem_wdata;
        end
    end

    assign mem_rdata       = rvalid_q ? mem_q[word_addr] : '0;
    assign mem_ready       = ready_q;
    assign mem_rdata_valid = rvalid_q;
    assign mem_wdata_ack   = wack_q;
    assign mem_beat        = beat_q;
    assign mem_done        = done_q;

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
Backing main-memory model and controller. It answers block-fill and block-writeback requests issued by the data cache inside the data-memory system, on the cache's lower-side interface. It serves whole cache blocks as a multi-beat burst, one word per cycle, after a fixed access latency. The cache raises `stall` to the core while a transfer is outstanding; this block is the far end of that stall-generating path.

Parameters:
- data_length, 32: word width in bits.
- address_length, 10: word-address width. Memory depth is 2**address_length words.
- block_words, 4: words per cache block. Must be a power of two, at least 2.
- latency, 4: idle cycles between request acceptance and the first data beat. Range is 0 to 255.

Ports:
- clock  in  1: single clock; all state updates on its rising edge.
- reset  in  1: synchronous, active-high.
- mem_req  in  1: request strobe from the cache. Sampled only when mem_ready=1.
- mem_write  in  1: 1 = writeback, 0 = block fill. Latched at acceptance.
- mem_block_addr  in  address_length-log2(block_words): block address. Latched at acceptance.
- mem_wdata  in  data_length: writeback beat data. Must match mem_beat while mem_wdata_ack=1.
- mem_ready  out  1: 1 only in IDLE.
- mem_rdata  out  data_length: fill beat data.
- mem_rdata_valid  out  1: fill beat present.
- mem_wdata_ack  out  1: writeback beat consumed this cycle.
- mem_beat  out  log2(block_words): index of the current beat.
- mem_done  out  1: one-cycle pulse ending a transaction.

Behaviour:
- State machine states: IDLE, WAIT, XFER, DONE.
- Reset values:
  - State is IDLE, so mem_ready=1.
  - mem_rdata_valid=0, mem_wdata_ack=0, mem_done=0.
  - mem_beat=0, mem_rdata=0.
  - Internal latency and beat counters are 0.
  - The storage array is NOT cleared by reset and retains its contents. It is zero at simulation start.
- IDLE:
  - If mem_req=1 at an edge, latch mem_write and mem_block_addr (acceptance edge E0).
  - Next state is WAIT with counter=latency-1, or XFER directly if latency=0.
  - If mem_req=0, stay in IDLE.
- WAIT:
  - Decrement the counter each edge.
  - Move to XFER with beat=0 on the edge where counter=0.
  - mem_req is ignored.
- XFER, one beat per cycle; word address = {latched_block, beat}:
  - Read: mem_rdata_valid=1, mem_rdata = array[word address] (combinational read of the latched address), mem_beat=beat.
  - Write: mem_wdata_ack=1, mem_beat=beat. The array word is written with mem_wdata at the edge ending the cycle.
  - At each edge, beat increments. On the edge where beat=block_words-1, move to DONE and wrap beat to 0.
- DONE:
  - mem_done=1 for exactly one cycle; all beat outputs are 0.
  - Next state is IDLE.
  - mem_ready is 0 during DONE, so back-to-back requests are separated by at least one DONE and one IDLE cycle.
- Timing, for latency L and block size B:
  - Beat i is present in the cycle following edge E0+L+i.
  - mem_done is high in the cycle after edge E0+L+B.
  - mem_ready returns after edge E0+L+B+1.
  - Total occupancy is L+B+2 cycles from the cycle of acceptance.
- mem_rdata outside read beats is held at 0.
- mem_req held high through a transaction has no effect until IDLE. If still high in IDLE, it is accepted as a new request.
- Reset mid-operation:
  - Aborts the transaction; return to IDLE at that edge.
  - Beats already written remain written. No further array writes occur, and mem_done is not pulsed.
  - A write beat whose cycle coincides with reset is NOT committed; reset has priority.
- Address wrap: the block at maximum mem_block_addr covers the top B words; the word address never exceeds depth-1.
- Only one transaction is outstanding at a time. No queueing.

Test Plan:
- Reset with L=4, B=4 -> mem_ready=1, all other outputs 0. Fill of block 0 returns four zero beats and mem_beat 0..3 once reset is released.
- Writeback to block 3 with beats 0xA0..0xA3:
  - Accepted at E0 -> mem_wdata_ack high in the cycles after E0+4..E0+7.
  - mem_done in the cycle after E0+8; mem_ready after E0+9.
- Then fill block 3 -> mem_rdata_valid for 4 cycles with data 0xA0,0xA1,0xA2,0xA3 and mem_beat 0,1,2,3. Block 2 is still all-zero.
- Build with latency=0 and fill block 255 (top block) after writing 0xDEAD0000+i:
  - First beat appears in the cycle after the acceptance edge.
  - Beats read back words 1020..1023 in order.
- Hold mem_req=1 continuously -> the second request is accepted only in the IDLE cycle following mem_done; exactly one DONE cycle lies between the two transactions.
- Assert reset during beat 2 of a writeback of 0x11..0x14 to block 5:
  - Words 20 and 21 are written; words 22 and 23 are unchanged.
  - mem_done is never pulsed; mem_ready=1 after the reset edge.
